// File: rtl/sram_ctrl.sv
// Multi-cycle SRAM controller for the MEM stage: freezes the pipeline while an access runs.
// Optional SRAM_CTRL_STATS_EN adds rd_count/wr_count completion counters.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [17:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [31:0] r_rdata;

  logic w_req;
  logic w_last;
  logic w_unused;

  assign w_req    = rd_en | wr_en;
  assign w_last   = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_unused = ^{address[31:20], address[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Write wins when both requests are raised together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= 18'd0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_addr  <= address[19:2];
        r_wdata <= writedata;
        r_wr    <= wr_en;
        r_cnt   <= CNT_INIT;
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_last && !r_wr) begin
        r_rdata <= sram_rdata;
      end
    end
  end

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_last) begin
      if (r_wr) begin
        r_wr_count <= r_wr_count + 16'd1;
      end else begin
        r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  always_comb begin
    w_next    = r_state;
    ready     = 1'b1;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          ready  = 1'b0;
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        ready     = 1'b0;
        sram_ce_n = 1'b0;
        if (r_wr) begin
          sram_we_n = 1'b0;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (r_cnt == 4'd0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Reset overrides the access immediately so the SRAM is never written mid-reset.
    if (!rst) begin
      ready     = 1'b1;
      sram_ce_n = 1'b1;
      sram_oe_n = 1'b1;
      sram_we_n = 1'b1;
    end
  end

  assign readdata   = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: vector table of single transactions
// plus back-to-back, reset-abort and (optional) statistics sequences.
module tb_sram_ctrl;

  localparam int W = 5;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .ready     (ready),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [17:0] exp_addr;
    logic [31:0] exp_rd;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  vec_t vecs[6];
  int   n_tests;
  int   n_fail;
  int   m_rd;
  int   m_wr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          c_done;
    int          n_oe;
    int          n_we;
    int          n_ce;
    logic [17:0] s_addr;
    logic [31:0] s_wdata;
    logic        r0;
    c_done  = -1;
    n_oe    = 0;
    n_we    = 0;
    n_ce    = 0;
    s_addr  = '0;
    s_wdata = '0;
    r0      = 1'b1;
    @(posedge clk);
    #1;
    rd_en      = v.rd;
    wr_en      = v.wr;
    address    = v.addr;
    writedata  = v.wdata;
    sram_rdata = v.rdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) r0 = ready;
      if (!sram_oe_n) n_oe++;
      if (!sram_we_n) n_we++;
      if (!sram_ce_n) begin
        n_ce++;
        s_addr  = sram_addr;
        s_wdata = sram_wdata;
      end
      if (ready && c > 0) begin
        c_done = c;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        break;
      end
    end
    if (v.wr) m_wr++;
    else m_rd++;
    check($sformatf("v%0d ready_c0", idx), 32'(r0), 32'd0);
    check($sformatf("v%0d latency", idx), 32'(c_done), 32'(W + 1));
    check($sformatf("v%0d ce_cycles", idx), 32'(n_ce), 32'(W));
    check($sformatf("v%0d oe_cycles", idx), 32'(n_oe), 32'(v.exp_oe));
    check($sformatf("v%0d we_cycles", idx), 32'(n_we), 32'(v.exp_we));
    check($sformatf("v%0d sram_addr", idx), 32'(s_addr), 32'(v.exp_addr));
    if (v.wr) begin
      check($sformatf("v%0d sram_wdata", idx), s_wdata, v.wdata);
    end
    check($sformatf("v%0d readdata", idx), readdata, v.exp_rd);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    m_rd       = 0;
    m_wr       = 0;
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    writedata  = '0;
    sram_rdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,
                32'hDEAD_BEEF, 18'h00101, 32'hDEAD_BEEF, W, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678,
                32'h0, 18'h00004, 32'hDEAD_BEEF, 0, W};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5,
                32'h1111_1111, 18'h00008, 32'hDEAD_BEEF, 0, W};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,
                32'hCAFE_F00D, 18'h3FFFF, 32'hCAFE_F00D, W, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h0010_0008, 32'h0,
                32'h0, 18'h00002, 32'h0, W, 0};
    vecs[5] = '{1'b0, 1'b1, 32'h000A_BCDE, 32'h0F0F_0F0F,
                32'h0, 18'h2AF37, 32'h0, 0, W};

    // Reset state, including the overrides while rst is low.
    rd_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst ce_n", 32'(sram_ce_n), 32'd1);
    check("rst oe_n", 32'(sram_oe_n), 32'd1);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst readdata", readdata, 32'd0);
    check("rst sram_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check("idle ready", 32'(ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], i);
    end

    // Back-to-back reads with rd_en held across DONE.
    @(posedge clk);
    #1;
    rd_en      = 1'b1;
    address    = 32'h0000_0100;
    sram_rdata = 32'h55AA_55AA;
    for (int c = 0; c < 14; c++) begin
      logic exp_rdy;
      @(negedge clk);
      exp_rdy = !((c <= W) || (c >= W + 2 && c <= 2 * W + 2));
      check($sformatf("b2b ready c%0d", c), 32'(ready), 32'(exp_rdy));
      if (c == W + 1 || c == W + 2) begin
        check($sformatf("b2b oe_n c%0d", c), 32'(sram_oe_n), 32'd1);
      end
      if (c == 13) rd_en = 1'b0;
    end
    m_rd += 2;
    check("b2b readdata", readdata, 32'h55AA_55AA);

`ifdef SRAM_CTRL_STATS_EN
    check("rd_count", 32'(rd_count), 32'(m_rd));
    check("wr_count", 32'(wr_count), 32'(m_wr));
`endif

    // Reset asserted in the third ACCESS cycle of a write.
    @(posedge clk);
    #1;
    wr_en     = 1'b1;
    address   = 32'h0000_0040;
    writedata = 32'h0BAD_0BAD;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort ready_in_rst", 32'(ready), 32'd1);
    check("abort we_n_in_rst", 32'(sram_we_n), 32'd1);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    check("abort ready", 32'(ready), 32'd1);
    check("abort we_n", 32'(sram_we_n), 32'd1);
    check("abort ce_n", 32'(sram_ce_n), 32'd1);
    check("abort readdata", readdata, 32'd0);
    check("abort sram_addr", 32'(sram_addr), 32'd0);
    check("abort sram_wdata", sram_wdata, 32'd0);
    @(negedge clk);
    check("abort idle ready", 32'(ready), 32'd1);
`ifdef SRAM_CTRL_STATS_EN
    check("rd_count cleared", 32'(rd_count), 32'd0);
    check("wr_count cleared", 32'(wr_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
